alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Sequencer that owns a WIDTH-bit ripple array of ALU bit-slices (add/sub/shift-left/shift-right) and runs multi-cycle commands on it.
- Accepts one command at a time on a valid/ready interface.
- Drives the array's operand and mode inputs each cycle and captures its result.
- Returns one response per command on a second valid/ready interface.
- Sits between the instruction/decode logic and the ALU array.

Parameters:
- WIDTH, 8, datapath width; also the bit count of the ALU array.
- SW, $clog2(WIDTH), width of the shift-amount field.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  controller can accept a command
- cmd_op  in  3  000 ADD, 001 SUB, 010 SHL, 011 SHR, 100 MUL, 101-111 illegal
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B; unused for SHL/SHR
- cmd_shamt  in  SW  shift amount, SHL/SHR only
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  consumer accepts response
- rsp_data  out  WIDTH  result
- rsp_cout  out  1  carry (ADD) / no-borrow (SUB), else 0
- rsp_err  out  1  illegal opcode
- busy  out  1  state != IDLE
- alu_A  out  WIDTH  array operand A
- alu_B  out  WIDTH  array operand B
- alu_mode  out  2  00 add, 01 sub (B inverted, Cin=1), 10 shift left, 11 shift right; array end fills are 0
- alu_Y  in  WIDTH  array result, combinational from alu_A/alu_B/alu_mode
- alu_cout  in  1  array MSB carry-out

Behaviour:
- Reset is synchronous, active-high, one clock, single reset domain.
  - Reset puts the block in IDLE and discards any in-flight command or pending response.
  - Reset values: cmd_rdy=1 after reset deasserts, rsp_vld=0, rsp_data=0, rsp_cout=0, rsp_err=0, busy=0, alu_A=0, alu_B=0, alu_mode=00.
- States: IDLE, EXEC, SHIFT, MUL_ADD, MUL_SHL, RESP.
- cmd_rdy=1 only in IDLE. A command is accepted on a cycle where cmd_vld && cmd_rdy.
- On accept, register op, a, b, shamt. Next state:
  - ADD/SUB -> EXEC.
  - SHL/SHR with shamt!=0 -> SHIFT, cnt=shamt.
  - SHL/SHR with shamt=0 -> RESP, data=a.
  - MUL -> MUL_ADD, acc=0, m=a, q=b, cnt=0.
  - Illegal op -> RESP, data=0, err=1.
- EXEC (1 cycle):
  - Drive alu_A=a, alu_B=b, alu_mode=00 (ADD) or 01 (SUB).
  - Capture data=alu_Y, cout=alu_cout, then go to RESP.
- SHIFT:
  - Each cycle drive alu_A=data, alu_B=0, alu_mode=10 or 11; data<=alu_Y; cnt--.
  - Leave for RESP after the cycle with cnt==1. Exactly shamt cycles. cout=0.
- MUL (shift-add, low WIDTH bits of product, fixed 2*WIDTH cycles, cout=0):
  - MUL_ADD: alu_A=acc, alu_B=q[0] ? m : 0, mode 00; acc<=alu_Y.
  - MUL_SHL: alu_A=m, alu_B=0, mode 10; m<=alu_Y; q<=q>>1; cnt++.
  - After MUL_SHL with cnt==WIDTH-1, go to RESP with data=acc.
  - Product overflow beyond WIDTH bits is silently dropped.
- In IDLE and RESP, alu_A/alu_B/alu_mode are held at 0/0/00.
- RESP:
  - rsp_vld=1; rsp_data/cout/err stable until the handshake.
  - On rsp_vld && rsp_rdy, return to IDLE and clear rsp_vld on the next edge.
- No command overlap: a new command can be accepted at the earliest one cycle after the response handshake.
- Latency, accept edge to first rsp_vld cycle:
  - ADD/SUB: 2.
  - Shift: shamt+1.
  - Shift by 0 and illegal: 1.
  - MUL: 2*WIDTH+1.
- rsp_rdy held high in RESP gives a 1-cycle response. rsp_rdy low stalls indefinitely with outputs frozen.
- cmd_vld, cmd fields and rsp_rdy are ignored outside IDLE/RESP respectively.
- Reset asserted in any state wins over every other event in that cycle.

Test Plan (WIDTH=8):
- ADD a=0xF0 b=0x20 -> rsp_data=0x10, rsp_cout=1, rsp_vld 2 cycles after accept; SUB a=0x05 b=0x07 -> 0xFE, cout=0; SUB 0x07-0x05 -> 0x02, cout=1.
- SHL a=0x81 shamt=3 -> 0x08 after 4 cycles; SHR a=0x80 shamt=7 -> 0x01 after 8 cycles; SHL shamt=0 a=0x5A -> 0x5A after 1 cycle; alu_mode observed 10/11 exactly shamt cycles.
- MUL 13*11 -> 0x8F; MUL 0x10*0x10 -> 0x00 (overflow dropped); MUL 0xFF*0x01 -> 0xFF; each rsp_vld exactly 17 cycles after accept.
- Backpressure: hold rsp_rdy=0 for 5 cycles in RESP -> rsp_vld and rsp_data stable; cmd_rdy=0; cmd_vld pulses during busy not accepted; the command accepted after the release executes correctly.
- Illegal op 110 -> rsp_err=1, rsp_data=0, 1-cycle latency; next legal ADD has rsp_err=0.
- Assert rst during MUL cycle 6 -> next cycle IDLE, rsp_vld=0, all outputs at reset values, no response emitted; a following ADD 1+1 -> 0x02.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// Command and response handshake bundle for the ALU sequencer.
// The master issues commands and consumes responses; the slave is the sequencer.
interface alu_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SW    = $clog2(WIDTH)
);
  logic             cmd_vld;
  logic             cmd_rdy;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [SW-1:0]    cmd_shamt;
  logic             rsp_vld;
  logic             rsp_rdy;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cout;
  logic             rsp_err;

  modport master (
    output cmd_vld, cmd_op, cmd_a, cmd_b, cmd_shamt, rsp_rdy,
    input  cmd_rdy, rsp_vld, rsp_data, rsp_cout, rsp_err
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_a, cmd_b, cmd_shamt, rsp_rdy,
    output cmd_rdy, rsp_vld, rsp_data, rsp_cout, rsp_err
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle command sequencer driving an external combinational ALU bit-slice array.
// ALU drive signals are registered one cycle ahead so they are valid for the whole state cycle.
module alu_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  alu_seq_ctrl_if.slave    bus,
  output logic             busy,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [1:0]       alu_mode,
  input  logic [WIDTH-1:0] alu_Y,
  input  logic             alu_cout
);

  typedef enum logic [2:0] {StIdle, StExec, StShift, StMulAdd, StMulShl, StResp} state_e;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpShl = 3'b010;
  localparam logic [2:0] OpShr = 3'b011;
  localparam logic [2:0] OpMul = 3'b100;

  state_e           state;
  logic [WIDTH-1:0] data;  // result register, doubles as the MUL accumulator
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic [SW-1:0]    cnt;
  logic             cout;
  logic             err;
  logic             out_vld;

  assign bus.cmd_rdy  = (state == StIdle);
  assign bus.rsp_vld  = out_vld;
  assign bus.rsp_data = data;
  assign bus.rsp_cout = cout;
  assign bus.rsp_err  = err;
  assign busy         = (state != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      data     <= '0;
      m        <= '0;
      q        <= '0;
      cnt      <= '0;
      cout     <= 1'b0;
      err      <= 1'b0;
      out_vld  <= 1'b0;
      alu_A    <= '0;
      alu_B    <= '0;
      alu_mode <= 2'b00;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.cmd_vld) begin
            cout <= 1'b0;
            err  <= 1'b0;
            case (bus.cmd_op)
              OpAdd, OpSub: begin
                state    <= StExec;
                alu_A    <= bus.cmd_a;
                alu_B    <= bus.cmd_b;
                alu_mode <= {1'b0, bus.cmd_op[0]};
              end
              OpShl, OpShr: begin
                data <= bus.cmd_a;
                if (bus.cmd_shamt == '0) begin
                  state   <= StResp;
                  out_vld <= 1'b1;
                end else begin
                  state    <= StShift;
                  cnt      <= bus.cmd_shamt;
                  alu_A    <= bus.cmd_a;
                  alu_B    <= '0;
                  alu_mode <= {1'b1, bus.cmd_op[0]};
                end
              end
              OpMul: begin
                state    <= StMulAdd;
                data     <= '0;
                m        <= bus.cmd_a;
                q        <= bus.cmd_b;
                cnt      <= '0;
                alu_A    <= '0;
                alu_B    <= bus.cmd_b[0] ? bus.cmd_a : '0;
                alu_mode <= 2'b00;
              end
              default: begin
                state   <= StResp;
                data    <= '0;
                err     <= 1'b1;
                out_vld <= 1'b1;
              end
            endcase
          end
        end
        StExec: begin
          data     <= alu_Y;
          cout     <= alu_cout;
          state    <= StResp;
          out_vld  <= 1'b1;
          alu_A    <= '0;
          alu_B    <= '0;
          alu_mode <= 2'b00;
        end
        StShift: begin
          data <= alu_Y;
          cnt  <= cnt - 1'b1;
          if (cnt == SW'(1)) begin
            state    <= StResp;
            out_vld  <= 1'b1;
            alu_A    <= '0;
            alu_mode <= 2'b00;
          end else begin
            alu_A <= alu_Y;
          end
        end
        StMulAdd: begin
          data     <= alu_Y;
          state    <= StMulShl;
          alu_A    <= m;
          alu_B    <= '0;
          alu_mode <= 2'b10;
        end
        StMulShl: begin
          m   <= alu_Y;
          q   <= q >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == SW'(WIDTH - 1)) begin
            state    <= StResp;
            out_vld  <= 1'b1;
            alu_A    <= '0;
            alu_B    <= '0;
            alu_mode <= 2'b00;
          end else begin
            // Next add uses the freshly shifted multiplicand and the next multiplier bit.
            state    <= StMulAdd;
            alu_A    <= data;
            alu_B    <= q[1] ? alu_Y : '0;
            alu_mode <= 2'b00;
          end
        end
        StResp: begin
          if (bus.rsp_rdy) begin
            state   <= StIdle;
            out_vld <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed testbench for alu_seq_ctrl with a behavioural model of the ALU array.
module tb_alu_seq_ctrl;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned SW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             busy;
  logic [WIDTH-1:0] alu_A;
  logic [WIDTH-1:0] alu_B;
  logic [1:0]       alu_mode;
  logic [WIDTH-1:0] alu_Y;
  logic             alu_cout;
  logic [WIDTH:0]   sum;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq_ctrl_if #(.WIDTH(WIDTH), .SW(SW)) bus ();

  alu_seq_ctrl #(.WIDTH(WIDTH), .SW(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .alu_A    (alu_A),
    .alu_B    (alu_B),
    .alu_mode (alu_mode),
    .alu_Y    (alu_Y),
    .alu_cout (alu_cout)
  );

  always #5 clk = ~clk;

  // ALU array model: add, subtract via inverted B with carry-in, shifts with zero fill.
  always_comb begin
    sum = '0;
    case (alu_mode)
      2'b00:   sum = {1'b0, alu_A} + {1'b0, alu_B};
      2'b01:   sum = {1'b0, alu_A} + {1'b0, ~alu_B} + {{WIDTH{1'b0}}, 1'b1};
      2'b10:   sum = {1'b0, alu_A << 1};
      default: sum = {1'b0, alu_A >> 1};
    endcase
    alu_Y    = sum[WIDTH-1:0];
    alu_cout = alu_mode[1] ? 1'b0 : sum[WIDTH];
  end

  // Issues one command and returns its latency and the number of shift-mode cycles seen.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sh, output int lat, output int sc);
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_shamt = sh;
    bus.cmd_vld   = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_vld = 1'b0;
    lat = 1;
    sc  = 0;
    while (!bus.rsp_vld && lat < 100) begin
      if (alu_mode[1]) sc++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_rsp();
    bus.rsp_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (bus.cmd_rdy !== 1'b1 || bus.rsp_vld !== 1'b0 || bus.rsp_data !== 8'h00 ||
        bus.rsp_cout !== 1'b0 || bus.rsp_err !== 1'b0 || busy !== 1'b0 ||
        alu_A !== 8'h00 || alu_B !== 8'h00 || alu_mode !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b vld=%b data=%h cout=%b err=%b busy=%b A=%h B=%h mode=%b",
               bus.cmd_rdy, bus.rsp_vld, bus.rsp_data, bus.rsp_cout, bus.rsp_err, busy,
               alu_A, alu_B, alu_mode);
    end
  endtask

  task automatic test_add_sub();
    logic [2:0] ops [3] = '{3'b000, 3'b001, 3'b001};
    logic [7:0] as  [3] = '{8'hF0, 8'h05, 8'h07};
    logic [7:0] bs  [3] = '{8'h20, 8'h07, 8'h05};
    logic [7:0] exp_d [3] = '{8'h10, 8'hFE, 8'h02};
    logic       exp_c [3] = '{1'b1, 1'b0, 1'b1};
    int lat, sc;
    for (int i = 0; i < 3; i++) begin
      run_cmd(ops[i], as[i], bs[i], 3'd0, lat, sc);
      n_checks++;
      if (lat != 2 || bus.rsp_data !== exp_d[i] || bus.rsp_cout !== exp_c[i] ||
          bus.rsp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL add_sub[%0d]: lat=%0d data=%h cout=%b err=%b, want lat=2 data=%h cout=%b",
                 i, lat, bus.rsp_data, bus.rsp_cout, bus.rsp_err, exp_d[i], exp_c[i]);
      end
      finish_rsp();
    end
  endtask

  task automatic test_shift();
    logic [2:0] ops [3] = '{3'b010, 3'b011, 3'b010};
    logic [7:0] as  [3] = '{8'h81, 8'h80, 8'h5A};
    logic [2:0] shs [3] = '{3'd3, 3'd7, 3'd0};
    logic [7:0] exp_d [3] = '{8'h08, 8'h01, 8'h5A};
    int lat, sc;
    for (int i = 0; i < 3; i++) begin
      run_cmd(ops[i], as[i], 8'hFF, shs[i], lat, sc);
      n_checks++;
      if (lat != int'(shs[i]) + 1 || sc != int'(shs[i]) || bus.rsp_data !== exp_d[i] ||
          bus.rsp_cout !== 1'b0) begin
        n_fail++;
        $display("FAIL shift[%0d]: lat=%0d modecyc=%0d data=%h cout=%b, want lat=%0d modecyc=%0d data=%h",
                 i, lat, sc, bus.rsp_data, bus.rsp_cout, shs[i] + 1, shs[i], exp_d[i]);
      end
      finish_rsp();
    end
  endtask

  task automatic test_mul();
    logic [7:0] as    [3] = '{8'd13, 8'h10, 8'hFF};
    logic [7:0] bs    [3] = '{8'd11, 8'h10, 8'h01};
    logic [7:0] exp_d [3] = '{8'h8F, 8'h00, 8'hFF};
    int lat, sc;
    for (int i = 0; i < 3; i++) begin
      run_cmd(3'b100, as[i], bs[i], 3'd0, lat, sc);
      n_checks++;
      if (lat != 17 || bus.rsp_data !== exp_d[i] || bus.rsp_cout !== 1'b0) begin
        n_fail++;
        $display("FAIL mul[%0d]: lat=%0d data=%h cout=%b, want lat=17 data=%h cout=0",
                 i, lat, bus.rsp_data, bus.rsp_cout, exp_d[i]);
      end
      finish_rsp();
    end
  endtask

  task automatic test_backpressure();
    int lat, sc;
    run_cmd(3'b000, 8'h11, 8'h22, 3'd0, lat, sc);
    for (int i = 0; i < 5; i++) begin
      bus.cmd_vld = (i % 2 == 1);
      bus.cmd_op  = 3'b000;
      bus.cmd_a   = 8'hAA;
      bus.cmd_b   = 8'h55;
      n_checks++;
      if (bus.rsp_vld !== 1'b1 || bus.rsp_data !== 8'h33 || bus.cmd_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: vld=%b data=%h rdy=%b, want vld=1 data=33 rdy=0",
                 i, bus.rsp_vld, bus.rsp_data, bus.cmd_rdy);
      end
      @(posedge clk);
      #1;
    end
    bus.cmd_vld = 1'b0;
    finish_rsp();
    n_checks++;
    if (busy !== 1'b0 || bus.cmd_rdy !== 1'b1 || bus.rsp_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: busy=%b rdy=%b vld=%b, want busy=0 rdy=1 vld=0",
               busy, bus.cmd_rdy, bus.rsp_vld);
    end
    run_cmd(3'b001, 8'h40, 8'h01, 3'd0, lat, sc);
    n_checks++;
    if (lat != 2 || bus.rsp_data !== 8'h3F || bus.rsp_cout !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_next: lat=%0d data=%h cout=%b, want lat=2 data=3f cout=1",
               lat, bus.rsp_data, bus.rsp_cout);
    end
    finish_rsp();
  endtask

  task automatic test_illegal();
    int lat, sc;
    run_cmd(3'b110, 8'h12, 8'h34, 3'd2, lat, sc);
    n_checks++;
    if (lat != 1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL illegal: lat=%0d err=%b data=%h, want lat=1 err=1 data=00",
               lat, bus.rsp_err, bus.rsp_data);
    end
    finish_rsp();
    run_cmd(3'b000, 8'h03, 8'h04, 3'd0, lat, sc);
    n_checks++;
    if (lat != 2 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 8'h07) begin
      n_fail++;
      $display("FAIL after_illegal: lat=%0d err=%b data=%h, want lat=2 err=0 data=07",
               lat, bus.rsp_err, bus.rsp_data);
    end
    finish_rsp();
  endtask

  task automatic test_reset_mid_mul();
    int lat, sc;
    int seen = 0;
    bus.cmd_op  = 3'b100;
    bus.cmd_a   = 8'd13;
    bus.cmd_b   = 8'd11;
    bus.cmd_vld = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_vld = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (bus.cmd_rdy !== 1'b1 || bus.rsp_vld !== 1'b0 || bus.rsp_data !== 8'h00 ||
        bus.rsp_cout !== 1'b0 || bus.rsp_err !== 1'b0 || busy !== 1'b0 ||
        alu_A !== 8'h00 || alu_B !== 8'h00 || alu_mode !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_mul: rdy=%b vld=%b data=%h busy=%b A=%h B=%h mode=%b",
               bus.cmd_rdy, bus.rsp_vld, bus.rsp_data, busy, alu_A, alu_B, alu_mode);
    end
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_vld === 1'b1) seen++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_no_rsp: rsp_vld cycles=%0d, want 0", seen);
    end
    run_cmd(3'b000, 8'h01, 8'h01, 3'd0, lat, sc);
    n_checks++;
    if (lat != 2 || bus.rsp_data !== 8'h02 || bus.rsp_cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_then_add: lat=%0d data=%h cout=%b, want lat=2 data=02 cout=0",
               lat, bus.rsp_data, bus.rsp_cout);
    end
    finish_rsp();
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_vld   = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_shamt = '0;
    bus.rsp_rdy   = 1'b0;
    test_reset();
    test_add_sub();
    test_shift();
    test_mul();
    test_backpressure();
    test_illegal();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
